// File: rtl/engine_clause_loader.sv
// Per-engine clause receive stage: queues clause nodes, latches the pointer bundle,
// and gates delivery to the BCP engine with a LOAD/RUN state machine.
// Latency: push at cycle N -> head visible at N+1 (show-ahead, no same-cycle bypass).
// Backpressure: pop_in consumes the head only in RUN; a push into a full queue without
//   a concurrent pop is dropped and flagged by the sticky overflow_out.
// Ports: clock/reset (sync, active-high); clause_in/clause_valid_in push side;
//   ptr_in/ptr_valid_in pointer-bundle load; flush_in clears everything back to LOAD;
//   pop_in/clause_out/clause_valid_out engine side; ptr_table_out/ptr_table_valid_out
//   latched bundle; engine_start_out one-cycle start pulse; count/full/empty/overflow status.
module engine_clause_loader #(
    parameter int CLQ_DEPTH   = 64,
    parameter int LIT_IDX_MAX = 4,
    parameter int NODE_W      = 32,
    parameter int PTR_W       = 16,
    localparam int AW         = $clog2(CLQ_DEPTH),
    localparam int CW         = AW + 1,
    localparam int BUNDLE_W   = 2 * LIT_IDX_MAX * PTR_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NODE_W-1:0]   clause_in,
    input  logic                clause_valid_in,
    input  logic [BUNDLE_W-1:0] ptr_in,
    input  logic                ptr_valid_in,
    input  logic                flush_in,
    input  logic                pop_in,
    output logic [NODE_W-1:0]   clause_out,
    output logic                clause_valid_out,
    output logic [BUNDLE_W-1:0] ptr_table_out,
    output logic                ptr_table_valid_out,
    output logic                engine_start_out,
    output logic [CW-1:0]       count_out,
    output logic                full_out,
    output logic                empty_out,
    output logic                overflow_out
);

    typedef enum logic {ST_LOAD, ST_RUN} state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [BUNDLE_W-1:0] ptr_tbl_q, ptr_tbl_d;
    logic                overflow_q, overflow_d;
    logic                start_q, start_d;
    logic [NODE_W-1:0]   mem_q [CLQ_DEPTH];

    logic full, empty, run, pop_fire, push_ok, mem_we;

    assign full     = (count_q == CW'(CLQ_DEPTH));
    assign empty    = (count_q == '0);
    assign run      = (state_q == ST_RUN);
    assign pop_fire = run & ~empty & pop_in;
    // A pop in the same cycle frees the slot a full-queue push needs.
    assign push_ok  = clause_valid_in & (~full | pop_fire);

    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        ptr_tbl_d  = ptr_tbl_q;
        overflow_d = overflow_q;
        start_d    = 1'b0;
        mem_we     = 1'b0;
        if (flush_in) begin
            // Flush outranks push, pop and pointer load in the same cycle.
            state_d    = ST_LOAD;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            ptr_tbl_d  = '0;
            overflow_d = 1'b0;
        end else begin
            if (push_ok) begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop_fire) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push_ok && !pop_fire) begin
                count_d = count_q + CW'(1);
            end else if (!push_ok && pop_fire) begin
                count_d = count_q - CW'(1);
            end
            if (clause_valid_in && !push_ok) begin
                overflow_d = 1'b1;
            end
            if (ptr_valid_in) begin
                ptr_tbl_d = ptr_in;
                state_d   = ST_RUN;
                // Reloading the table while already running does not restart the engine.
                start_d   = (state_q == ST_LOAD);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_LOAD;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            ptr_tbl_q  <= '0;
            overflow_q <= 1'b0;
            start_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            ptr_tbl_q  <= ptr_tbl_d;
            overflow_q <= overflow_d;
            start_q    <= start_d;
        end
    end

    // Storage needs no reset: stale entries are unreachable once the pointers clear.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= clause_in;
        end
    end

    assign clause_out          = empty ? '0 : mem_q[rd_ptr_q];
    assign clause_valid_out    = run & ~empty;
    assign ptr_table_out       = ptr_tbl_q;
    assign ptr_table_valid_out = run;
    assign engine_start_out    = start_q;
    assign count_out           = count_q;
    assign full_out            = full;
    assign empty_out           = empty;
    assign overflow_out        = overflow_q;

endmodule

// File: tb/tb_engine_clause_loader.sv
// Directed bench for engine_clause_loader with a pop-side scoreboard.
// Stimulus pushes expected clauses into a queue; a negedge monitor checks every pop.
// Status outputs are checked directly 1 time unit after the clock edge.
module tb_engine_clause_loader;

    localparam int D  = 64;
    localparam int NW = 32;
    localparam int PW = 16;
    localparam int BW = 2 * 4 * PW;
    localparam int CW = $clog2(D) + 1;

    logic          clock = 1'b0;
    logic          reset;
    logic [NW-1:0] clause_in;
    logic          clause_valid_in;
    logic [BW-1:0] ptr_in;
    logic          ptr_valid_in;
    logic          flush_in;
    logic          pop_in;
    logic [NW-1:0] clause_out;
    logic          clause_valid_out;
    logic [BW-1:0] ptr_table_out;
    logic          ptr_table_valid_out;
    logic          engine_start_out;
    logic [CW-1:0] count_out;
    logic          full_out;
    logic          empty_out;
    logic          overflow_out;

    engine_clause_loader #(.CLQ_DEPTH(D), .LIT_IDX_MAX(4), .NODE_W(NW), .PTR_W(PW)) dut (
        .clock               (clock),
        .reset               (reset),
        .clause_in           (clause_in),
        .clause_valid_in     (clause_valid_in),
        .ptr_in              (ptr_in),
        .ptr_valid_in        (ptr_valid_in),
        .flush_in            (flush_in),
        .pop_in              (pop_in),
        .clause_out          (clause_out),
        .clause_valid_out    (clause_valid_out),
        .ptr_table_out       (ptr_table_out),
        .ptr_table_valid_out (ptr_table_valid_out),
        .engine_start_out    (engine_start_out),
        .count_out           (count_out),
        .full_out            (full_out),
        .empty_out           (empty_out),
        .overflow_out        (overflow_out)
    );

    always #5 clock = ~clock;

    int            tests = 0;
    int            fails = 0;
    logic [NW-1:0] exp_q [$];
    logic [NW-1:0] mon_exp;
    logic [BW-1:0] bundle1, bundle2;
    int            max_cnt;

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_exp(input logic [NW-1:0] d);
        exp_q.push_back(d);
    endtask

    // Monitor: a pop fires at the next edge whenever the head is valid and pop_in is high.
    always @(negedge clock) begin
        if (!reset && !flush_in && clause_valid_out && pop_in) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL pop_unexpected: got %0h expected no entry", clause_out);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("pop_data", BW'(clause_out), BW'(mon_exp));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < 8; k++) begin
            bundle1[k*PW +: PW] = PW'(k + 1);
        end
        bundle2 = ~bundle1;

        reset = 1'b1; clause_in = '0; clause_valid_in = 1'b0; ptr_in = '0;
        ptr_valid_in = 1'b0; flush_in = 1'b0; pop_in = 1'b0;
        step(); step();
        chk("rst_clause_out", BW'(clause_out), '0);
        chk("rst_cv", BW'(clause_valid_out), '0);
        chk("rst_tbl", ptr_table_out, '0);
        chk("rst_tbl_vld", BW'(ptr_table_valid_out), '0);
        chk("rst_start", BW'(engine_start_out), '0);
        chk("rst_count", BW'(count_out), '0);
        chk("rst_full", BW'(full_out), '0);
        chk("rst_empty", BW'(empty_out), 1);
        chk("rst_ovf", BW'(overflow_out), '0);
        reset = 1'b0;

        // Pushes in LOAD are stored but not delivered; pop is ignored.
        for (int i = 0; i < 3; i++) begin
            clause_valid_in = 1'b1; clause_in = 32'hA0 + NW'(i); push_exp(clause_in);
            step();
        end
        clause_valid_in = 1'b0;
        chk("load_count3", BW'(count_out), 3);
        chk("load_cv", BW'(clause_valid_out), '0);
        pop_in = 1'b1;
        repeat (5) step();
        chk("load_pop_ignored", BW'(count_out), 3);

        // Pointer load -> RUN, start pulse, drain A,B,C.
        ptr_valid_in = 1'b1; ptr_in = bundle1;
        step();
        ptr_valid_in = 1'b0; ptr_in = '0;
        chk("run_tbl_vld", BW'(ptr_table_valid_out), 1);
        chk("run_start", BW'(engine_start_out), 1);
        chk("run_tbl", ptr_table_out, bundle1);
        chk("run_cv", BW'(clause_valid_out), 1);
        step();
        chk("start_one_cycle", BW'(engine_start_out), '0);
        step();
        step();
        pop_in = 1'b0;
        chk("drained_empty", BW'(empty_out), 1);
        chk("drained_cv", BW'(clause_valid_out), '0);

        // Reload in RUN overwrites the table without a new start pulse.
        ptr_valid_in = 1'b1; ptr_in = bundle2;
        step();
        ptr_valid_in = 1'b0; ptr_in = '0;
        chk("reload_tbl", ptr_table_out, bundle2);
        chk("reload_no_start", BW'(engine_start_out), '0);

        // Fill to 64; the first push must not bypass to the output in its own cycle.
        for (int i = 0; i < D; i++) begin
            clause_valid_in = 1'b1; clause_in = 32'h100 + NW'(i); push_exp(clause_in);
            if (i == 0) begin
                #1;
                chk("no_bypass", BW'(clause_valid_out), '0);
            end
            step();
        end
        clause_valid_in = 1'b0;
        chk("fill_full", BW'(full_out), 1);
        chk("fill_count", BW'(count_out), D);
        chk("fill_no_ovf", BW'(overflow_out), '0);

        // Push and pop together on a full queue.
        clause_valid_in = 1'b1; clause_in = 32'h200; pop_in = 1'b1; push_exp(clause_in);
        step();
        clause_valid_in = 1'b0; pop_in = 1'b0;
        chk("pushpop_count", BW'(count_out), D);
        chk("pushpop_no_ovf", BW'(overflow_out), '0);

        // Dropped push on a full queue.
        clause_valid_in = 1'b1; clause_in = 32'hDEAD;
        step();
        clause_valid_in = 1'b0;
        chk("ovf_set", BW'(overflow_out), 1);
        chk("ovf_count", BW'(count_out), D);

        pop_in = 1'b1;
        repeat (D) step();
        pop_in = 1'b0;
        chk("drain_all_empty", BW'(empty_out), 1);
        chk("drain_all_count", BW'(count_out), '0);

        // Streaming wrap-around.
        pop_in = 1'b1; max_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            clause_valid_in = 1'b1; clause_in = 32'h1000 + NW'(i); push_exp(clause_in);
            step();
            if (int'(count_out) > max_cnt) max_cnt = int'(count_out);
        end
        clause_valid_in = 1'b0;
        step(); step();
        pop_in = 1'b0;
        chk("wrap_max_le4", BW'(max_cnt <= 4), 1);
        chk("wrap_empty", BW'(empty_out), 1);
        chk("ovf_sticky", BW'(overflow_out), 1);

        // Flush with 10 queued plus a concurrent push.
        for (int i = 0; i < 10; i++) begin
            clause_valid_in = 1'b1; clause_in = 32'h2000 + NW'(i); push_exp(clause_in);
            step();
        end
        chk("pre_flush_count", BW'(count_out), 10);
        clause_in = 32'hBAD; flush_in = 1'b1; exp_q.delete();
        step();
        clause_valid_in = 1'b0; flush_in = 1'b0;
        chk("flush_count", BW'(count_out), '0);
        chk("flush_empty", BW'(empty_out), 1);
        chk("flush_tbl_vld", BW'(ptr_table_valid_out), '0);
        chk("flush_ovf", BW'(overflow_out), '0);
        chk("flush_tbl", ptr_table_out, '0);

        // Back in LOAD: pop ignored.
        clause_valid_in = 1'b1; clause_in = 32'h300; pop_in = 1'b1; push_exp(clause_in);
        step();
        clause_valid_in = 1'b0;
        chk("flush_load_cv", BW'(clause_valid_out), '0);
        step();
        chk("flush_load_count", BW'(count_out), 1);

        // Same-cycle pointer and clause in LOAD.
        pop_in = 1'b0; ptr_valid_in = 1'b1; ptr_in = bundle1;
        clause_valid_in = 1'b1; clause_in = 32'h301; push_exp(clause_in);
        step();
        ptr_valid_in = 1'b0; clause_valid_in = 1'b0;
        chk("dual_start", BW'(engine_start_out), 1);
        chk("dual_count", BW'(count_out), 2);
        chk("dual_head", BW'(clause_out), 32'h300);
        pop_in = 1'b1;
        step(); step();
        pop_in = 1'b0;
        chk("dual_empty", BW'(empty_out), 1);

        // Synchronous reset mid-stream with a concurrent push.
        for (int i = 0; i < 5; i++) begin
            clause_valid_in = 1'b1; clause_in = 32'h3000 + NW'(i); push_exp(clause_in);
            step();
        end
        clause_in = 32'hBEEF; reset = 1'b1; exp_q.delete();
        step();
        reset = 1'b0; clause_valid_in = 1'b0;
        chk("rst2_count", BW'(count_out), '0);
        chk("rst2_empty", BW'(empty_out), 1);
        chk("rst2_tbl_vld", BW'(ptr_table_valid_out), '0);
        chk("rst2_tbl", ptr_table_out, '0);
        chk("rst2_cv", BW'(clause_valid_out), '0);
        step();

        chk("scoreboard_drained", BW'(exp_q.size()), '0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
